// File: rtl/iterative_divider.sv
// Multicycle restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// Start/Busy/Done handshake, registered Quotient (to LO) and Remainder (to HI).
module iterative_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             SignedOp,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero
);

   // Handshake: Start is taken on a rising edge only while Busy=0 (state IDLE);
   // Done is a one-cycle pulse issued from IDLE, so Start in the Done cycle is accepted.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] quo_out_q, quo_out_d;
   logic [WIDTH-1:0] rem_out_q, rem_out_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             last_step;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      logic [WIDTH-1:0] r;
      r = v;
      if (is_signed && v[WIDTH-1]) begin
         r = (~v) + ONE;
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
      logic [WIDTH-1:0] r;
      r = v;
      if (neg) begin
         r = (~v) + ONE;
      end
      return r;
   endfunction

   // State register and datapath flops
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         dvd_q     <= '0;
         dsr_q     <= '0;
         cnt_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         zero_q    <= 1'b0;
         quo_out_q <= '0;
         rem_out_q <= '0;
         dbz_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         dsr_q     <= dsr_d;
         cnt_q     <= cnt_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         zero_q    <= zero_d;
         quo_out_q <= quo_out_d;
         rem_out_q <= rem_out_d;
         dbz_q     <= dbz_d;
         done_q    <= done_d;
      end
   end

   assign last_step = (cnt_q == CNT_LAST);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (Start) state_d = S_RUN;
         S_RUN:    if (last_step) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // One restoring step: the extra top bit of the subtractor is the borrow.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dsr_q};

   always_comb begin
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      dsr_d     = dsr_q;
      cnt_d     = cnt_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      zero_d    = zero_q;
      quo_out_d = quo_out_q;
      rem_out_d = rem_out_q;
      dbz_d     = dbz_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               dvd_d   = magnitude(Dividend, SignedOp);
               dsr_d   = magnitude(Divisor, SignedOp);
               q_neg_d = SignedOp & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
               r_neg_d = SignedOp & Dividend[WIDTH-1];
               zero_d  = (Divisor == '0);
               rem_d   = '0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_ONE;
         end
         S_FINISH: begin
            // With a zero divisor every trial succeeds, so rem_q holds |Dividend|;
            // re-applying the dividend sign reproduces Dividend bit-for-bit.
            quo_out_d = zero_q ? '1 : negate_if(dvd_q, q_neg_q);
            rem_out_d = negate_if(rem_q, r_neg_q);
            dbz_d     = zero_q;
            done_d    = 1'b1;
         end
         default: ;
      endcase
   end

   // Output logic
   always_comb begin
      Busy      = (state_q != S_IDLE);
      Done      = done_q;
      Quotient  = quo_out_q;
      Remainder = rem_out_q;
      DivByZero = dbz_q;
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed DIV/DIVU cases, handshake
// corner cases, mid-operation reset and random operands against a reference model.
module tb_iterative_divider;

   localparam int W       = 32;
   localparam int LATENCY = W + 1;

   logic         clk;
   logic         reset;
   logic         start;
   logic         signed_op;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int done_seen    = 0;

   logic [2*W:0] exp_q[$];
   int           acc_q[$];

   iterative_divider #(.WIDTH(W), .CNT_W(6)) dut (
      .Clk       (clk),
      .Reset     (reset),
      .Start     (start),
      .SignedOp  (signed_op),
      .Dividend  (dividend),
      .Divisor   (divisor),
      .Busy      (busy),
      .Done      (done),
      .Quotient  (quotient),
      .Remainder (remainder),
      .DivByZero (div_by_zero)
   );

   // Clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: {div_by_zero, quotient, remainder}
   function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q;
      logic [W-1:0] r;
      longint       sa;
      longint       sb;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {(b == '0), q, r};
   endfunction

   // Driver: called at a negedge, holds Start for one edge, returns at the next negedge
   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic expect_accept);
      start     = 1'b1;
      signed_op = s;
      dividend  = a;
      divisor   = b;
      if (expect_accept) begin
         exp_q.push_back(model(s, a, b));
         acc_q.push_back(cyc + 1);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      start_op(s, a, b, 1'b1);
      wait_done(LATENCY + 8);
   endtask

   // Scoreboard: pop and compare on every Done
   always @(negedge clk) begin
      logic [2*W:0] e;
      int           acc;
      if (done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e   = exp_q.pop_front();
            acc = acc_q.pop_front();
            check("quotient", quotient, e[2*W-1:W]);
            check("remainder", remainder, e[W-1:0]);
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[2*W]});
            check("latency", W'(cyc - acc), W'(LATENCY));
         end
      end
   end

   initial begin
      logic         rs;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           d0;

      reset     = 1'b1;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);

      // DIVU 100/7 with Busy profile over the whole operation
      start_op(1'b0, 32'd100, 32'd7, 1'b1);
      check("busy_c0", {31'd0, busy}, 32'd1);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         check($sformatf("busy_c%0d", i), {31'd0, busy}, 32'd1);
         check($sformatf("nodone_c%0d", i), {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("done_pulse", {31'd0, done}, 32'd1);
      repeat (3) @(negedge clk);
      check("done_drop", {31'd0, done}, 32'd0);
      check("hold_quotient", quotient, 32'd14);
      check("hold_remainder", remainder, 32'd2);

      // Signed and unsigned directed cases
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
      run_op(1'b0, 32'hFFFF_FFFF, 32'h10);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 32'h8000_0000, 32'd1);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 32'd5, 32'd0);
      run_op(1'b0, 32'd100, 32'd7);
      run_op(1'b1, 32'hFFFF_FFFB, 32'd0);
      run_op(1'b0, 32'hFFFF_FFFB, 32'd0);
      run_op(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC);
      run_op(1'b0, 32'd3, 32'd9);

      // Start during Busy is ignored; Start in the Done cycle is accepted
      @(negedge clk);
      start_op(1'b0, 32'd100, 32'd7, 1'b1);
      repeat (9) @(negedge clk);
      start_op(1'b0, 32'd9, 32'd3, 1'b0);
      wait_done(LATENCY + 8);
      start_op(1'b0, 32'd9, 32'd3, 1'b1);
      wait_done(LATENCY + 8);

      // Random operands, occasional zero divisor
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rs = 1'($urandom_range(0, 1));
         ra = $urandom();
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom() >> $urandom_range(0, 31);
         run_op(rs, ra, rb);
      end

      // Reset in the middle of an operation discards it
      @(negedge clk);
      start_op(1'b0, 32'd100, 32'd7, 1'b1);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_quotient", quotient, 32'd0);
      check("mid_rst_remainder", remainder, 32'd0);
      check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
      d0 = done_seen;
      repeat (40) @(negedge clk);
      check("no_done_after_rst", W'(done_seen - d0), 32'd0);

      check("scoreboard_drain", W'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
